// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer: state encoding, default tap
// count and the tap-index width derivation used by control and datapath.
package fir_pkg;

    localparam int NTAPS_DEF = 8;

    // Tap-index width for a given tap count; never narrower than one bit.
    function automatic int tap_width(input int ntaps);
        return (ntaps < 2) ? 1 : $clog2(ntaps);
    endfunction

    localparam int TAP_W_DEF = tap_width(NTAPS_DEF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_MAC   = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index counter: counts 0..NTAPS-1 while enabled, returns to 0 after the
// terminal tap so it never runs past the last coefficient.
module fir_tap_counter
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int TAP_W = tap_width(NTAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [TAP_W-1:0] cnt,
    output logic             tc
);

    logic [TAP_W-1:0] cnt_q;
    logic [TAP_W-1:0] cnt_d;

    assign tc  = (cnt_q == TAP_W'(NTAPS - 1));
    assign cnt = cnt_q;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + TAP_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_ctrl.sv
// FIR filter sequencer: accepts a sample, shifts the delay line, walks the
// taps through a shared MAC and holds the result until downstream takes it.
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int TAP_W = tap_width(NTAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    input  logic             flush,
    output logic             shift_en,
    output logic             dl_clr,
    output logic [TAP_W-1:0] tap_idx,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             busy
);

    logic [1:0] state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       shift_en_q, shift_en_d;
    logic       dl_clr_q, dl_clr_d;
    logic       mac_en_q, mac_en_d;
    logic       mac_clr_q, mac_clr_d;
    logic       busy_q, busy_d;
    logic       cnt_clr, cnt_en, cnt_tc;

    fir_tap_counter #(
        .NTAPS (NTAPS),
        .TAP_W (TAP_W)
    ) u_tap_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (tap_idx),
        .tc  (cnt_tc)
    );

    assign cnt_clr = flush || (state_q != ST_MAC);
    assign cnt_en  = (state_q == ST_MAC);

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (in_valid && in_ready_q) state_d = ST_SHIFT;
                ST_SHIFT: state_d = ST_MAC;
                ST_MAC:   if (cnt_tc) state_d = ST_OUT;
                ST_OUT:   if (out_ready) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so each one is a plain flop.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE) && !flush;
        out_valid_d = (state_d == ST_OUT);
        shift_en_d  = (state_d == ST_SHIFT);
        dl_clr_d    = flush;
        mac_en_d    = (state_d == ST_MAC);
        mac_clr_d   = (state_d == ST_MAC) && (state_q != ST_MAC);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            shift_en_q  <= 1'b0;
            dl_clr_q    <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            shift_en_q  <= shift_en_d;
            dl_clr_q    <= dl_clr_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign shift_en  = shift_en_q;
    assign dl_clr    = dl_clr_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign busy      = busy_q;

endmodule
